// File: rtl/data_memory.sv
// rtl/data_memory.sv - load/store data memory with wait states, byte/half/word lanes and alignment checking
// Stores commit only on the BUSY->RESP edge, so a reset during BUSY leaves memory untouched.
module data_memory #(
    parameter int w           = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic         memwrite,
    input  logic [w-1:0] addr,
    input  logic [w-1:0] wd,
    input  logic [1:0]   size,
    input  logic         unsigned_ld,
    output logic [w-1:0] rd,
    output logic         ready,
    output logic         misaligned
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wd;
    logic [1:0]    r_size;
    logic          r_we;
    logic          r_uns;
    logic [w-1:0]  r_rd;
    logic          r_ready;
    logic          r_mis;

    logic [w-1:0]  r_mem [DEPTH];

    logic          w_req_err;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_do_access;
    logic [w-1:0]  w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [w-1:0]  w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_unused_addr;

    // Address bits above the word index alias onto the same array
    assign w_unused_addr = &{1'b0, addr[w-1:AW+2]};

    assign w_req_err = (size == 2'b11)
                     | ((size == 2'b01) & addr[0])
                     | ((size == 2'b10) & (|addr[1:0]));

    assign w_idx       = r_addr[AW+1:2];
    assign w_lane      = r_addr[1:0];
    assign w_do_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_word      = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[{w_lane, 3'b000} +: 8];
        w_half = w_word[{w_lane[1], 4'b0000} +: 16];
        w_load = w_word;
        case (r_size)
            2'b00:   w_load = r_uns ? {{(w-8){1'b0}}, w_byte}
                                    : {{(w-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {{(w-16){1'b0}}, w_half}
                                    : {{(w-16){w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Byte data is replicated across lanes; the enables pick which lanes land
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wd;
        case (r_size)
            2'b00: begin
                w_be         = 4'b0000;
                w_be[w_lane] = 1'b1;
                w_wdata      = {4{r_wd[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wd[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wd;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_access && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_rd    <= '0;
            r_ready <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_mis   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr <= addr[AW+1:0];
                        r_wd   <= wd[31:0];
                        r_size <= size;
                        r_we   <= memwrite;
                        r_uns  <= unsigned_ld;
                        if (w_req_err) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_mis   <= 1'b1;
                            r_rd    <= '0;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) begin
                            r_rd <= w_load;
                        end
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd         = r_rd;
    assign ready      = r_ready;
    assign misaligned = r_mis;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - table-driven scoreboard bench for data_memory
module tb_data_memory;
    localparam int W     = 32;
    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          memwrite = 1'b0;
    logic [W-1:0]  addr = '0;
    logic [W-1:0]  wd = '0;
    logic [1:0]    size = 2'b00;
    logic          unsigned_ld = 1'b0;
    logic [W-1:0]  rd;
    logic          ready;
    logic          misaligned;

    data_memory #(.w(W), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .memwrite    (memwrite),
        .addr        (addr),
        .wd          (wd),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .rd          (rd),
        .ready       (ready),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        uns;
        logic        err;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rd = 32'h0;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse retires one expected response
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'(ready), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_rd"}, rd, e.rd);
                chk({e.name, "_mis"}, 32'(misaligned), 32'(e.mis));
            end
        end
    end

    task automatic access(input vec_t v);
        exp_t e;
        int   lat;
        @(negedge clk);
        memwrite    = v.we;
        addr        = v.a;
        wd          = v.d;
        size        = v.sz;
        unsigned_ld = v.uns;
        req         = 1'b1;
        if (v.err)       m_rd = 32'h0;
        else if (!v.we)  m_rd = v.exp_rd;
        e.rd   = m_rd;
        e.mis  = v.err;
        e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, "_lat"}, 32'(lat), v.err ? 32'd1 : 32'(WS + 2));
        @(posedge clk);
        #1;
        chk({v.name, "_pulse"}, 32'(ready), 32'h0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, input logic uns, input logic err,
                                input logic [31:0] exp_rd, input string name);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.sz = sz; v.uns = uns;
        v.err = err; v.exp_rd = exp_rd; v.name = name;
        return v;
    endfunction

    initial begin
        vec_t v;
        vecs.push_back(mk(1, 32'h10,  32'hAAAA_BBBB, 2'b10, 0, 0, 32'h0,         "st_w10"));
        vecs.push_back(mk(0, 32'h10,  32'h0,         2'b10, 0, 0, 32'hAAAA_BBBB, "ld_w10"));
        vecs.push_back(mk(1, 32'h20,  32'h1111_22F0, 2'b10, 0, 0, 32'h0,         "st_w20"));
        vecs.push_back(mk(0, 32'h20,  32'h0,         2'b00, 0, 0, 32'hFFFF_FFF0, "ld_bs20"));
        vecs.push_back(mk(0, 32'h20,  32'h0,         2'b00, 1, 0, 32'h0000_00F0, "ld_bu20"));
        vecs.push_back(mk(0, 32'h21,  32'h0,         2'b00, 0, 0, 32'h0000_0022, "ld_bs21"));
        vecs.push_back(mk(0, 32'h22,  32'h0,         2'b01, 0, 0, 32'h0000_1111, "ld_hs22"));
        vecs.push_back(mk(1, 32'h30,  32'hFFFF_FFFF, 2'b10, 0, 0, 32'h0,         "st_w30"));
        vecs.push_back(mk(1, 32'h32,  32'hDEAD_1234, 2'b01, 0, 0, 32'h0,         "st_h32"));
        vecs.push_back(mk(0, 32'h30,  32'h0,         2'b10, 0, 0, 32'h1234_FFFF, "ld_w30a"));
        vecs.push_back(mk(0, 32'h31,  32'h0,         2'b10, 0, 1, 32'h0,         "ld_w31_err"));
        vecs.push_back(mk(1, 32'h33,  32'h0000_BEEF, 2'b01, 0, 1, 32'h0,         "st_h33_err"));
        vecs.push_back(mk(0, 32'h30,  32'h0,         2'b10, 0, 0, 32'h1234_FFFF, "ld_w30b"));
        vecs.push_back(mk(1, 32'h30,  32'h0,         2'b11, 0, 1, 32'h0,         "st_sz3_err"));
        vecs.push_back(mk(1, 32'h31,  32'h0000_0080, 2'b00, 0, 0, 32'h0,         "st_b31"));
        vecs.push_back(mk(0, 32'h30,  32'h0,         2'b10, 0, 0, 32'h1234_80FF, "ld_w30c"));
        vecs.push_back(mk(0, 32'h30,  32'h0,         2'b01, 0, 0, 32'hFFFF_80FF, "ld_hs30"));
        vecs.push_back(mk(0, 32'h30,  32'h0,         2'b01, 1, 0, 32'h0000_80FF, "ld_hu30"));
        vecs.push_back(mk(1, 32'h400, 32'hCAFE_F00D, 2'b10, 0, 0, 32'h0,         "st_wrap"));
        vecs.push_back(mk(0, 32'h0,   32'h0,         2'b10, 0, 0, 32'hCAFE_F00D, "ld_wrap"));
        vecs.push_back(mk(1, 32'h40,  32'h0102_0304, 2'b10, 0, 0, 32'h0,         "st_w40"));

        #12;
        chk("reset_rd", rd, 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_mis", 32'(misaligned), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) access(vecs[i]);

        // Reset during BUSY aborts the store and clears outputs at once
        @(negedge clk);
        memwrite = 1'b1; addr = 32'h40; wd = 32'h5555_5555; size = 2'b10; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rd", rd, 32'h0);
        chk("abort_ready", 32'(ready), 32'h0);
        chk("abort_mis", 32'(misaligned), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_rd = 32'h0;
        v = mk(0, 32'h40, 32'h0, 2'b10, 0, 0, 32'h0102_0304, "ld_w40_abort");
        access(v);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
